// File: rtl/dmem_pkg.sv
// Shared defaults, FSM state encoding and requester indices for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 64;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned NWORDS_DEF = 128;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_DBG = 1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from request valids and the last granted index.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            // Contention: favour whichever requester was not served last.
            2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
            default: o_grant = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and debug/DMA requesters onto a single-ported data memory,
// one outstanding transaction at a time, with a registered response stage.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NWORDS = NWORDS_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_write_data,
    output logic                   mem_write_en,
    output logic                   mem_read_en,
    input  logic [DATA_W-1:0]      mem_read_data,
    output logic                   busy
);

    state_t              r_state;
    logic                r_last;
    logic                r_owner;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;

    logic [1:0]          w_grant;
    logic                w_sel;
    logic                w_active;
    logic                w_legal;
    logic                w_go;
    logic [ADDR_W-1:0]   w_addr;

    rr_arb2 u_arb (
        .i_valid (req_valid),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    assign w_sel   = w_grant[REQ_DBG];
    assign w_addr  = req_addr[w_sel];
    assign w_legal = (w_addr[2:0] == 3'b000) && ((w_addr >> 3) < ADDR_W'(NWORDS));

    // rstn gates the grant directly so an asynchronous reset kills the write strobe mid-cycle.
    assign w_active = rstn && (r_state == IDLE) && (|req_valid);
    assign w_go     = w_active && w_legal;

    assign req_ready      = w_active ? w_grant : '0;
    assign mem_address    = w_go ? w_addr : '0;
    assign mem_write_data = w_go ? req_wdata[w_sel] : '0;
    assign mem_write_en   = w_go && req_we[w_sel];
    assign mem_read_en    = w_go && !req_we[w_sel];

    assign busy      = (r_state != IDLE);
    assign rsp_valid = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_active) begin
                        r_owner <= w_sel;
                        r_last  <= w_sel;
                        r_rdata <= (w_legal && !req_we[w_sel]) ? mem_read_data : '0;
                        r_err   <= !w_legal;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_dmem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int NW = 128;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][DW-1:0]  req_wdata;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DW-1:0]       rsp_rdata;
    logic                rsp_err;
    logic [AW-1:0]       mem_address;
    logic [DW-1:0]       mem_write_data;
    logic                mem_write_en;
    logic                mem_read_en;
    logic [DW-1:0]       mem_read_data;
    logic                busy;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NWORDS(NW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    // Behavioural data memory: combinational read, write on the rising edge.
    logic [DW-1:0] mem [NW] = '{default: '0};
    assign mem_read_data = mem[mem_address[9:3]];
    always @(posedge clk) if (mem_write_en) mem[mem_address[9:3]] <= mem_write_data;

    typedef struct {
        logic        idx;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        owner;
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input logic owner, input logic [63:0] rdata, input logic err);
        rsp_t e;
        e.owner = owner;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        rsp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: got response %0h expected none queued", rsp_valid);
        end else begin
            e = sb.pop_front();
            chk("rsp_valid", rsp_valid, e.owner ? 64'd2 : 64'd1);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err",   rsp_err,   e.err);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        req_valid         = 2'b01 << v.idx;
        req_we[v.idx]     = v.we;
        req_addr[v.idx]   = v.addr;
        req_wdata[v.idx]  = v.wdata;
        rsp_ready         = 2'b00;
        sb_push(v.idx, v.exp_rdata, v.exp_err);
        @(negedge clk);
        chk("grant",   req_ready,    2'b01 << v.idx);
        chk("wr_en",   mem_write_en, !v.exp_err && v.we);
        chk("rd_en",   mem_read_en,  !v.exp_err && !v.we);
        chk("mem_addr", mem_address, v.exp_err ? 64'd0 : v.addr);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b01 << v.idx;
        if (v.we && !v.exp_err) chk("mem_word", mem[v.addr[9:3]], v.wdata);
        @(negedge clk);
        chk("resp_busy",  busy, 1);
        chk("resp_ready", req_ready, 0);
        chk("resp_en",    {mem_write_en, mem_read_en}, 0);
        sb_check();
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("idle_busy",  busy, 0);
        chk("idle_rsp",   rsp_valid, 0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs = '{
            '{1'b0, 1'b1, 64'h10,  64'hDEADBEEF,            1'b0, 64'h0},
            '{1'b0, 1'b0, 64'h10,  64'h0,                   1'b0, 64'hDEADBEEF},
            '{1'b1, 1'b1, 64'h3F8, 64'h123456789ABCDEF0,    1'b0, 64'h0},
            '{1'b1, 1'b0, 64'h3F8, 64'h0,                   1'b0, 64'h123456789ABCDEF0},
            '{1'b0, 1'b0, 64'h13,  64'h0,                   1'b1, 64'h0},
            '{1'b1, 1'b1, 64'h400, 64'hBAD,                 1'b1, 64'h0},
            '{1'b0, 1'b0, 64'h0,   64'h0,                   1'b0, 64'h0},
            '{1'b1, 1'b0, 64'h10,  64'h0,                   1'b0, 64'hDEADBEEF},
            '{1'b0, 1'b1, 64'h8,   64'hA5A5A5A55A5A5A5A,    1'b0, 64'h0},
            '{1'b1, 1'b0, 64'h8,   64'h0,                   1'b0, 64'hA5A5A5A55A5A5A5A},
            '{1'b0, 1'b1, 64'h14,  64'hFFFF,                1'b1, 64'h0},
            '{1'b0, 1'b0, 64'h10,  64'h0,                   1'b0, 64'hDEADBEEF}
        };

        // Reset with both requesters valid: nothing may be granted or enabled.
        req_valid = 2'b11;
        req_we    = 2'b11;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 2'b00;
        #12;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp",   rsp_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_en",    {mem_write_en, mem_read_en}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err",   rsp_err, 0);
        req_valid = 2'b00;
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Backpressure with the other requester waiting and non-owner rsp_ready asserted.
        @(posedge clk); #1;
        req_valid   = 2'b01;
        req_we      = 2'b00;
        req_addr[0] = 64'h10;
        req_addr[1] = 64'h3F8;
        rsp_ready   = 2'b00;
        sb_push(1'b0, 64'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("bp_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 2'b01);
            chk("bp_rdata", rsp_rdata, 64'hDEADBEEF);
            chk("bp_busy",  busy, 1);
            chk("bp_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        @(negedge clk);
        sb_check();
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("bp_next_grant", req_ready, 2'b10);
        chk("bp_next_busy",  busy, 0);
        sb_push(1'b1, 64'h123456789ABCDEF0, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        @(negedge clk);
        sb_check();
        @(posedge clk); #1;
        rsp_ready = 2'b00;

        // Reset asserted inside a grant cycle must kill the write strobe at once.
        @(posedge clk); #1;
        req_valid    = 2'b01;
        req_we[0]    = 1'b1;
        req_addr[0]  = 64'h18;
        req_wdata[0] = 64'h55;
        #2;
        chk("gr_wen_before", mem_write_en, 1);
        rstn = 1'b0;
        #1;
        chk("gr_wen_reset",  mem_write_en, 0);
        chk("gr_rdy_reset",  req_ready, 0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("gr_mem_kept", mem[3], 0);
        @(negedge clk);
        rstn = 1'b1;

        // Reset during RESP drops the pending response.
        @(posedge clk); #1;
        req_valid   = 2'b01;
        req_we      = 2'b00;
        req_addr[0] = 64'h10;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("mr_valid_before", rsp_valid, 2'b01);
        #2;
        rstn = 1'b0;
        #1;
        chk("mr_valid_reset", rsp_valid, 0);
        chk("mr_busy_reset",  busy, 0);
        chk("mr_rdata_reset", rsp_rdata, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("mr_valid_after", rsp_valid, 0);
        chk("mr_busy_after",  busy, 0);

        // Contention: CPU wins first after reset, then strict alternation.
        @(posedge clk); #1;
        req_valid   = 2'b11;
        req_we      = 2'b00;
        req_addr[0] = 64'h10;
        req_addr[1] = 64'h3F8;
        rsp_ready   = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ct_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            chk("ct_onehot", &req_ready, 0);
            if (k % 2 == 1) sb_push(1'b1, 64'h123456789ABCDEF0, 1'b0);
            else            sb_push(1'b0, 64'hDEADBEEF, 1'b0);
            @(negedge clk);
            chk("ct_resp_ready", req_ready, 0);
            sb_check();
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
